// File: rtl/pu_stream_driver.sv
// pu_stream_driver
//   Synthesizable stimulus and checker for processing-unit test harnesses.
//   Streams generated input neurons (NUM_PE lanes per word, row tails
//   zero-padded) over a W x H x C x B feature map. Every PU write is compared
//   against the head of an expected-word FIFO filled by the bench or a host.
//   A watchdog fails the run if the PU goes quiet for TIMEOUT cycles.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               1-cycle pulse, latches cfg_* and enters RUN (ignored in RUN)
//   cfg_width/height/channels/batch   feature-map dimensions (each >= 1)
//   cfg_num_writes      PU writes expected before completion (>= 1)
//   pu_rd_req/pu_rd_ready             read handshake
//   pu_data_in/pu_data_valid          input word, valid 1 cycle after accept
//   pu_wr_req/pu_data_out             PU write strobe and output word
//   exp_valid/exp_ready/exp_data      expected-word FIFO push port
//   busy, pass, fail    run status (pass/fail sticky until the next start)
//   err_count           saturating error count
//   first_err_idx       write index of the first error, all-ones if none
//
// State | meaning
//   IDLE | after reset, waiting for start
//   RUN  | streaming reads and checking writes
//   PASS | all expected writes seen with no error
//   FAIL | error, overrun or watchdog expiry
module pu_stream_driver #(
    parameter int OP_WIDTH  = 16,
    parameter int NUM_PE    = 4,
    parameter int EXP_DEPTH = 16,
    parameter int TIMEOUT   = 10000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [15:0]                  cfg_width,
    input  logic [15:0]                  cfg_height,
    input  logic [15:0]                  cfg_channels,
    input  logic [15:0]                  cfg_batch,
    input  logic [31:0]                  cfg_num_writes,
    input  logic                         pu_rd_req,
    output logic                         pu_rd_ready,
    output logic [OP_WIDTH*NUM_PE-1:0]   pu_data_in,
    output logic                         pu_data_valid,
    input  logic                         pu_wr_req,
    input  logic [OP_WIDTH*NUM_PE-1:0]   pu_data_out,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [OP_WIDTH*NUM_PE-1:0]   exp_data,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic [15:0]                  err_count,
    output logic [31:0]                  first_err_idx
);

    localparam int DATA_WIDTH = OP_WIDTH * NUM_PE;
    localparam int AW         = $clog2(EXP_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t state, next_state;

    logic [15:0] cfg_w_q, cfg_h_q, cfg_c_q, cfg_b_q;
    logic [31:0] cfg_nw_q;

    // Read-side position; w_cnt is one bit wider so w+NUM_PE cannot wrap.
    logic [16:0]         w_cnt;
    logic [15:0]         h_cnt, c_cnt, b_cnt;
    logic [OP_WIDTH-1:0] row_base;
    logic                rd_done;
    logic                row_end;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [31:0] wd_cnt;
    logic [31:0] wr_cnt, wr_cnt_nx;
    logic [15:0] err_count_nx;

    logic [DATA_WIDTH-1:0] fifo_mem [EXP_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic start_ok, in_run, rd_accept, run_wr, run_err, ovr_err, any_err, wd_expire;

    // ---------------- status decode ----------------
    assign in_run     = (state == S_RUN);
    assign start_ok   = start && !in_run;
    assign rd_accept  = pu_rd_req && pu_rd_ready;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_push  = exp_valid && !fifo_full;
    assign fifo_pop   = pu_wr_req && !fifo_empty;
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
    assign exp_ready  = !fifo_full;

    assign run_wr     = in_run && pu_wr_req;
    assign run_err    = run_wr && (fifo_empty || (fifo_head != pu_data_out));
    assign ovr_err    = pu_wr_req && ((state == S_PASS) || (state == S_FAIL));
    assign any_err    = run_err || ovr_err;

    assign wr_cnt_nx    = wr_cnt + {31'd0, run_wr};
    assign err_count_nx = (any_err && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

    // Last idle cycle of the watchdog window; the count is reloaded on activity.
    assign wd_expire  = in_run && !rd_accept && !pu_wr_req && (wd_cnt == 32'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= next_state;
            pass  <= (next_state == S_PASS);
            fail  <= (next_state == S_FAIL);
        end
    end

    // ---------------- FSM: next state ----------------
    // Completion looks at this cycle's write so pass/fail rise on the edge
    // that samples the final write.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_RUN;
            S_RUN: begin
                if (wr_cnt_nx == cfg_nw_q)
                    next_state = (err_count_nx == 16'd0) ? S_PASS : S_FAIL;
                else if (wd_expire)
                    next_state = S_FAIL;
            end
            S_PASS: begin
                if (start)        next_state = S_RUN;
                else if (ovr_err) next_state = S_FAIL;
            end
            S_FAIL: if (start) next_state = S_RUN;
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = in_run;
        pu_rd_ready = in_run && !rd_done;
    end

    // ---------------- read word generation ----------------
    assign row_end = ((w_cnt + 17'(NUM_PE)) >= {1'b0, cfg_w_q});

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if ((w_cnt + 17'(i)) < {1'b0, cfg_w_q})
                rd_word[i*OP_WIDTH +: OP_WIDTH] = row_base + OP_WIDTH'(w_cnt + 17'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pu_data_in    <= '0;
            pu_data_valid <= 1'b0;
        end else begin
            pu_data_valid <= rd_accept;
            if (rd_accept) pu_data_in <= rd_word;
        end
    end

    // ---------------- run counters, watchdog, checker ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_w_q       <= '0;
            cfg_h_q       <= '0;
            cfg_c_q       <= '0;
            cfg_b_q       <= '0;
            cfg_nw_q      <= '0;
            w_cnt         <= '0;
            h_cnt         <= '0;
            c_cnt         <= '0;
            b_cnt         <= '0;
            row_base      <= '0;
            rd_done       <= 1'b0;
            wd_cnt        <= '0;
            wr_cnt        <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else if (start_ok) begin
            cfg_w_q       <= cfg_width;
            cfg_h_q       <= cfg_height;
            cfg_c_q       <= cfg_channels;
            cfg_b_q       <= cfg_batch;
            cfg_nw_q      <= cfg_num_writes;
            w_cnt         <= '0;
            h_cnt         <= '0;
            c_cnt         <= '0;
            b_cnt         <= '0;
            row_base      <= '0;
            rd_done       <= 1'b0;
            wd_cnt        <= 32'(TIMEOUT);
            wr_cnt        <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            if (in_run) begin
                if (rd_accept || pu_wr_req) wd_cnt <= 32'(TIMEOUT);
                else if (wd_cnt != 32'd0)  wd_cnt <= wd_cnt - 32'd1;
            end

            // Rows are consecutive in index space, so the row base simply
            // advances by W at every row end.
            if (rd_accept) begin
                if (row_end) begin
                    w_cnt    <= '0;
                    row_base <= row_base + OP_WIDTH'(cfg_w_q);
                    if (h_cnt == cfg_h_q - 16'd1) begin
                        h_cnt <= '0;
                        if (c_cnt == cfg_c_q - 16'd1) begin
                            c_cnt <= '0;
                            if (b_cnt == cfg_b_q - 16'd1) rd_done <= 1'b1;
                            else                          b_cnt   <= b_cnt + 16'd1;
                        end else begin
                            c_cnt <= c_cnt + 16'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 16'd1;
                    end
                end else begin
                    w_cnt <= w_cnt + 17'(NUM_PE);
                end
            end

            if (run_wr) wr_cnt <= wr_cnt_nx;

            if (any_err) begin
                err_count <= err_count_nx;
                if (err_count == 16'd0) first_err_idx <= wr_cnt;
            end
        end
    end

    // ---------------- expected-word FIFO ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= exp_data;
    end

endmodule

// File: tb/tb_pu_stream_driver.sv
module tb_pu_stream_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] cfg_width, cfg_height, cfg_channels, cfg_batch;
    logic [31:0] cfg_num_writes;
    logic        pu_rd_req, pu_rd_ready;
    logic [63:0] pu_data_in;
    logic        pu_data_valid;
    logic        pu_wr_req;
    logic [63:0] pu_data_out;
    logic        exp_valid, exp_ready;
    logic [63:0] exp_data;
    logic        busy, pass, fail;
    logic [15:0] err_count;
    logic [31:0] first_err_idx;

    pu_stream_driver #(
        .OP_WIDTH (16),
        .NUM_PE   (4),
        .EXP_DEPTH(16),
        .TIMEOUT  (50)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_channels  (cfg_channels),
        .cfg_batch     (cfg_batch),
        .cfg_num_writes(cfg_num_writes),
        .pu_rd_req     (pu_rd_req),
        .pu_rd_ready   (pu_rd_ready),
        .pu_data_in    (pu_data_in),
        .pu_data_valid (pu_data_valid),
        .pu_wr_req     (pu_wr_req),
        .pu_data_out   (pu_data_out),
        .exp_valid     (exp_valid),
        .exp_ready     (exp_ready),
        .exp_data      (exp_data),
        .busy          (busy),
        .pass          (pass),
        .fail          (fail),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkw(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; pu_rd_req = 0; pu_wr_req = 0; exp_valid = 0;
        pu_data_out = '0; exp_data = '0;
        cfg_width = 0; cfg_height = 0; cfg_channels = 0; cfg_batch = 0; cfg_num_writes = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
    endtask

    task automatic start_run(input int w, input int h, input int c, input int b, input int nw);
        cfg_width = 16'(w); cfg_height = 16'(h); cfg_channels = 16'(c); cfg_batch = 16'(b);
        cfg_num_writes = 32'(nw);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic push_exp(input logic [63:0] d);
        exp_valid = 1; exp_data = d;
        tick();
        exp_valid = 0;
    endtask

    task automatic pu_write(input logic [63:0] d);
        pu_wr_req = 1; pu_data_out = d;
        tick();
        pu_wr_req = 0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rd_ready"}, 64'(pu_rd_ready), 64'd0);
        check({pfx, "_valid"},    64'(pu_data_valid), 64'd0);
        check({pfx, "_data_in"},  pu_data_in, 64'd0);
        check({pfx, "_busy"},     64'(busy), 64'd0);
        check({pfx, "_pass"},     64'(pass), 64'd0);
        check({pfx, "_fail"},     64'(fail), 64'd0);
        check({pfx, "_err"},      64'(err_count), 64'd0);
        check({pfx, "_first"},    64'(first_err_idx), 64'hFFFF_FFFF);
        check({pfx, "_exp_rdy"},  64'(exp_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp1 [4];
        logic [63:0] w3 [3];
        int k;
        logic acc;

        clear_inputs();
        reset_n = 0;
        #23;
        check_reset_values("rst");
        @(negedge clk);
        reset_n = 1;
        tick();

        // 1: W=6,H=2 with padded row tails, req held high
        exp1[0] = mkw(0, 1, 2, 3);
        exp1[1] = mkw(4, 5, 0, 0);
        exp1[2] = mkw(6, 7, 8, 9);
        exp1[3] = mkw(10, 11, 0, 0);
        start_run(6, 2, 1, 1, 1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_rdy", 64'(pu_rd_ready), 64'd1);
        pu_rd_req = 1;
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (pu_data_valid) begin
                if (k < 4) check($sformatf("t1_word%0d", k), pu_data_in, exp1[k]);
                k++;
                if (k == 4) check("t1_rdy_low", 64'(pu_rd_ready), 64'd0);
            end
        end
        pu_rd_req = 0;
        check("t1_nwords", 64'(k), 64'd4);
        check("t1_valid_off", 64'(pu_data_valid), 64'd0);
        check("t1_hold", pu_data_in, exp1[3]);

        // 2: W=4,H=1,C=2,B=2 with random request gaps
        do_reset();
        start_run(4, 1, 2, 2, 1);
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 4; cyc++) begin
            pu_rd_req = ((cyc % 4) == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            acc = pu_rd_req && pu_rd_ready;
            tick();
            check("t2_valid", 64'(pu_data_valid), 64'(acc));
            if (acc) begin
                check($sformatf("t2_word%0d", k), pu_data_in, mkw(4*k, 4*k+1, 4*k+2, 4*k+3));
                k++;
            end
        end
        pu_rd_req = 0;
        check("t2_nwords", 64'(k), 64'd4);
        check("t2_rdy_low", 64'(pu_rd_ready), 64'd0);

        // 3: three matching writes -> PASS, then overrun -> FAIL
        do_reset();
        w3[0] = 64'h1111_2222_3333_4444;
        w3[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        w3[2] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) push_exp(w3[i]);
        start_run(4, 1, 1, 1, 3);
        pu_write(w3[0]);
        pu_write(w3[1]);
        check("t3_pass_early", 64'(pass), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        pu_write(w3[2]);
        check("t3_pass", 64'(pass), 64'd1);
        check("t3_fail", 64'(fail), 64'd0);
        check("t3_busy_off", 64'(busy), 64'd0);
        check("t3_err", 64'(err_count), 64'd0);
        check("t3_first", 64'(first_err_idx), 64'hFFFF_FFFF);
        pu_write(64'h5);
        check("t3_ovr_fail", 64'(fail), 64'd1);
        check("t3_ovr_pass", 64'(pass), 64'd0);
        check("t3_ovr_err", 64'(err_count), 64'd1);

        // 4: corrupted 2nd write plus a write after completion (restart from FAIL)
        for (int i = 0; i < 3; i++) push_exp(w3[i]);
        start_run(4, 1, 1, 1, 3);
        check("t4_fail_clr", 64'(fail), 64'd0);
        check("t4_err_clr", 64'(err_count), 64'd0);
        check("t4_first_clr", 64'(first_err_idx), 64'hFFFF_FFFF);
        pu_write(w3[0]);
        pu_write(w3[1] ^ 64'h1);
        pu_write(w3[2]);
        check("t4_fail", 64'(fail), 64'd1);
        check("t4_pass", 64'(pass), 64'd0);
        check("t4_err1", 64'(err_count), 64'd1);
        check("t4_first", 64'(first_err_idx), 64'd1);
        pu_write(w3[2]);
        check("t4_err2", 64'(err_count), 64'd2);
        check("t4_first_keep", 64'(first_err_idx), 64'd1);
        check("t4_fail_keep", 64'(fail), 64'd1);

        // 5: FIFO full / push+pop boundaries, write on empty FIFO
        do_reset();
        for (int i = 0; i < 15; i++) push_exp(64'(i));
        check("t5_rdy_15", 64'(exp_ready), 64'd1);
        exp_valid = 1; exp_data = 64'd99; pu_wr_req = 1; pu_data_out = '0;
        tick();
        exp_valid = 0; pu_wr_req = 0;
        check("t5_pushpop_keep", 64'(exp_ready), 64'd1);
        push_exp(64'd100);
        check("t5_full", 64'(exp_ready), 64'd0);
        exp_valid = 1; exp_data = 64'd101; pu_wr_req = 1;
        tick();
        exp_valid = 0; pu_wr_req = 0;
        check("t5_full_pop", 64'(exp_ready), 64'd1);
        push_exp(64'd102);
        check("t5_refull", 64'(exp_ready), 64'd0);
        do_reset();
        start_run(4, 1, 1, 1, 2);
        pu_write(64'h5);
        check("t5_empty_err", 64'(err_count), 64'd1);
        check("t5_empty_first", 64'(first_err_idx), 64'd0);
        check("t5_empty_busy", 64'(busy), 64'd1);

        // 6: watchdog expiry after 50 idle RUN cycles, then async reset mid-RUN
        do_reset();
        start_run(4, 1, 1, 1, 1);
        repeat (49) tick();
        check("t6_fail_49", 64'(fail), 64'd0);
        check("t6_busy_49", 64'(busy), 64'd1);
        tick();
        check("t6_fail_50", 64'(fail), 64'd1);
        check("t6_busy_50", 64'(busy), 64'd0);
        start_run(4, 2, 1, 1, 1);
        push_exp(64'h77);
        pu_rd_req = 1;
        tick();
        tick();
        check("t6_valid_pre", 64'(pu_data_valid), 64'd1);
        #2;
        reset_n = 0;
        pu_rd_req = 0;
        #1;
        check_reset_values("t6_rst");
        tick();
        reset_n = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
